// File: rtl/shift_sequencer.sv
// Iterative ARM operand-2 shifter: moves up to STEP bits per cycle and produces
// the full shifter carry-out, with a start/busy/done handshake for pipeline stalls.
module shift_sequencer #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        mem_rw,
  input  logic        imm,
  input  logic [11:0] shift_operand,
  input  logic [31:0] val_rm,
  input  logic [7:0]  val_rs,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] val2,
  output logic        carry_out
);

  // Handshake: start is sampled only in IDLE; busy stays high from the cycle
  // after an accepted start through the done cycle; done is a one-cycle pulse
  // with val2/carry_out valid, and both hold until the next completed operation.

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] M_LSL = 3'd0;
  localparam logic [2:0] M_LSR = 3'd1;
  localparam logic [2:0] M_ASR = 3'd2;
  localparam logic [2:0] M_ROR = 3'd3;
  localparam logic [2:0] M_RRX = 3'd4;

  state_t      state_q;
  logic [31:0] work_q;
  logic [5:0]  rem_q;
  logic [2:0]  mode_q;
  logic        carry_q;
  logic        sign_q;

  logic [5:0]  set_eff;
  logic [2:0]  set_mode;
  logic [31:0] set_work;
  logic [31:0] set_val;
  logic        set_carry;

  // Operand decode at start; set_val/set_carry are the result when eff is 0.
  always_comb begin
    set_eff   = 6'd0;
    set_mode  = {1'b0, shift_operand[6:5]};
    set_work  = val_rm;
    set_val   = val_rm;
    set_carry = carry_in;
    if (mem_rw) begin
      set_val = {20'b0, shift_operand};
    end else if (imm) begin
      set_mode = M_ROR;
      set_work = {24'b0, shift_operand[7:0]};
      set_val  = {24'b0, shift_operand[7:0]};
      set_eff  = {1'b0, shift_operand[11:8], 1'b0};
    end else if (shift_operand[4]) begin
      if (val_rs == 8'd0) begin
        set_eff = 6'd0;
      end else if (shift_operand[6:5] == 2'b11) begin
        if (val_rs[4:0] == 5'd0) set_carry = val_rm[31];
        else                     set_eff   = {1'b0, val_rs[4:0]};
      end else begin
        set_eff = (val_rs > 8'd33) ? 6'd33 : val_rs[5:0];
      end
    end else if (shift_operand[11:7] != 5'd0) begin
      set_eff = {1'b0, shift_operand[11:7]};
    end else begin
      case (shift_operand[6:5])
        2'b01, 2'b10: set_eff = 6'd32;
        2'b11: begin
          set_mode = M_RRX;
          set_eff  = 6'd1;
        end
        default: set_eff = 6'd0;
      endcase
    end
  end

  logic [5:0]  step_n;
  logic [4:0]  lsl_idx;
  logic [4:0]  rsh_idx;
  logic [31:0] fill_mask;
  logic [31:0] ror_val;
  logic [31:0] nxt_work;
  logic        nxt_carry;

  assign step_n  = (rem_q > 6'(STEP)) ? 6'(STEP) : rem_q;
  assign lsl_idx = 5'(6'd32 - step_n);
  assign rsh_idx = 5'(step_n - 6'd1);

  always_comb begin
    fill_mask = ~(32'hFFFF_FFFF >> step_n);
    ror_val   = (work_q >> step_n) | (work_q << (6'd32 - step_n));
    nxt_work  = work_q;
    nxt_carry = carry_q;
    case (mode_q)
      M_LSL: begin
        nxt_work  = work_q << step_n;
        nxt_carry = work_q[lsl_idx];
      end
      M_LSR: begin
        nxt_work  = work_q >> step_n;
        nxt_carry = work_q[rsh_idx];
      end
      M_ASR: begin
        nxt_work  = (work_q >> step_n) | (sign_q ? fill_mask : 32'h0);
        nxt_carry = work_q[rsh_idx];
      end
      M_ROR: begin
        nxt_work  = ror_val;
        nxt_carry = ror_val[31];
      end
      M_RRX: begin
        nxt_work  = {carry_q, work_q[31:1]};
        nxt_carry = work_q[0];
      end
      default: begin
        nxt_work  = work_q;
        nxt_carry = carry_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      rem_q     <= '0;
      mode_q    <= M_LSL;
      carry_q   <= 1'b0;
      sign_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      val2      <= '0;
      carry_out <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      rem_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work_q  <= set_work;
            mode_q  <= set_mode;
            rem_q   <= set_eff;
            carry_q <= set_carry;
            sign_q  <= set_work[31];
            busy    <= 1'b1;
            if (set_eff == 6'd0) begin
              state_q   <= DONE;
              done      <= 1'b1;
              val2      <= set_val;
              carry_out <= set_carry;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q  <= nxt_work;
          carry_q <= nxt_carry;
          rem_q   <= rem_q - step_n;
          if (rem_q <= 6'(STEP)) begin
            state_q   <= DONE;
            done      <= 1'b1;
            val2      <= nxt_work;
            carry_out <= nxt_carry;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, hand-written flush/reset
// sequences, and randomized operations checked against a one-shot arithmetic model.
module tb_shift_sequencer;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        mem_rw = 1'b0;
  logic        imm = 1'b0;
  logic [11:0] shift_operand = '0;
  logic [31:0] val_rm = '0;
  logic [7:0]  val_rs = '0;
  logic        carry_in = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] val2;
  logic        carry_out;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  shift_sequencer #(.STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .mem_rw(mem_rw),
    .imm(imm), .shift_operand(shift_operand), .val_rm(val_rm), .val_rs(val_rs),
    .carry_in(carry_in), .busy(busy), .done(done), .val2(val2), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic        i;
    logic [11:0] op;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        cin;
    int          restart;
    logic [31:0] ev;
    logic        ec;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic i, input logic [11:0] op,
                              input logic [31:0] rm, input logic [7:0] rs, input logic cin,
                              input int restart, input logic [31:0] ev, input logic ec,
                              input int lat);
    vec_t v;
    v.m = m; v.i = i; v.op = op; v.rm = rm; v.rs = rs; v.cin = cin;
    v.restart = restart; v.ev = ev; v.ec = ec; v.lat = lat;
    return v;
  endfunction

  // Whole shift in one step on 64-bit values; valid for amounts 1..33.
  function automatic void shift64(input int mode, input logic [31:0] rm, input int n,
                                  output logic [31:0] v, output logic c);
    logic [63:0] t;
    case (mode)
      0: begin t = {32'b0, rm} << n; v = t[31:0]; c = t[32]; end
      1: begin t = {rm, 32'b0} >> n; v = t[63:32]; c = t[31]; end
      2: begin t = $signed({rm, 32'b0}) >>> n; v = t[63:32]; c = t[31]; end
      default: begin t = {rm, rm} >> n; v = t[31:0]; c = v[31]; end
    endcase
  endfunction

  function automatic void model(input logic m, input logic i, input logic [11:0] op,
                                input logic [31:0] rm, input logic [7:0] rs, input logic cin,
                                output logic [31:0] v, output logic c, output int eff);
    logic [63:0] t;
    int mode;
    int n;
    v = rm; c = cin; eff = 0;
    mode = int'(op[6:5]);
    if (m) begin
      v = {20'b0, op};
    end else if (i) begin
      n = 2 * int'(op[11:8]);
      t = {24'b0, op[7:0], 24'b0, op[7:0]} >> n;
      v = t[31:0];
      c = (n == 0) ? cin : v[31];
      eff = n;
    end else if (op[4]) begin
      if (rs == 8'd0) begin
        eff = 0;
      end else if (mode == 3) begin
        n = int'(rs) % 32;
        if (n == 0) c = rm[31];
        else shift64(3, rm, n, v, c);
        eff = n;
      end else begin
        n = (int'(rs) > 33) ? 33 : int'(rs);
        shift64(mode, rm, n, v, c);
        eff = n;
      end
    end else begin
      n = int'(op[11:7]);
      if (n == 0 && mode == 3) begin
        v = {cin, rm[31:1]};
        c = rm[0];
        eff = 1;
      end else if (n == 0 && mode == 0) begin
        eff = 0;
      end else begin
        if (n == 0) n = 32;
        shift64(mode, rm, n, v, c);
        eff = n;
      end
    end
  endfunction

  // Called just after a rising edge (start of cycle C0); returns likewise.
  task automatic run_op(input logic m, input logic i, input logic [11:0] op,
                        input logic [31:0] rm, input logic [7:0] rs, input logic cin,
                        input int restart, input logic [31:0] ev, input logic ec,
                        input int lat, input string name);
    int got;
    logic busy_ok;
    mem_rw = m; imm = i; shift_operand = op; val_rm = rm; val_rs = rs; carry_in = cin;
    start = 1'b1;
    got = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 50 && got < 0; c++) begin
      @(posedge clk);
      #1;
      start = (c == restart);
      if (c == restart) begin
        mem_rw = 1'b1;
        shift_operand = 12'hFFF;
      end
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) got = c;
    end
    start = 1'b0;
    chk({name, " latency"}, got, lat);
    chk({name, " busy"}, {31'b0, busy_ok}, 32'd1);
    chk({name, " val2"}, val2, ev);
    chk({name, " carry"}, {31'b0, carry_out}, {31'b0, ec});
    if (got > 0) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({name, " done_pulse"}, {30'b0, done, busy}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[14];

  initial begin
    logic [31:0] mv;
    logic        mc;
    int          meff;
    logic        rm_m, rm_i, rm_cin;
    logic [11:0] r_op;
    logic [31:0] r_rm;
    logic [7:0]  r_rs;

    tbl[0]  = mk(1, 0, 12'hABC, 32'h0,         8'd0,   1, 0, 32'h0000_0ABC, 1, 1);
    tbl[1]  = mk(0, 1, 12'h4FF, 32'h0,         8'd0,   0, 0, 32'hFF00_0000, 1, 3);
    tbl[2]  = mk(0, 0, 12'h020, 32'h8000_0001, 8'd0,   0, 4, 32'h0000_0000, 1, 9);
    tbl[3]  = mk(0, 0, 12'h010, 32'hFFFF_FFFF, 8'd40,  1, 0, 32'h0000_0000, 0, 10);
    tbl[4]  = mk(0, 0, 12'h070, 32'h8000_0000, 8'd32,  0, 0, 32'h8000_0000, 1, 1);
    tbl[5]  = mk(0, 0, 12'h060, 32'h0000_0003, 8'd0,   0, 0, 32'h0000_0001, 1, 2);
    tbl[6]  = mk(0, 0, 12'h000, 32'h1234_5678, 8'd0,   1, 0, 32'h1234_5678, 1, 1);
    tbl[7]  = mk(0, 0, 12'h040, 32'h8000_0000, 8'd0,   0, 0, 32'hFFFF_FFFF, 1, 9);
    tbl[8]  = mk(0, 0, 12'h050, 32'h7FFF_FFFF, 8'd200, 1, 0, 32'h0000_0000, 0, 10);
    tbl[9]  = mk(0, 0, 12'h030, 32'h8000_0000, 8'd32,  0, 0, 32'h0000_0000, 1, 9);
    tbl[10] = mk(0, 0, 12'h080, 32'h8000_0001, 8'd0,   0, 0, 32'h0000_0002, 1, 2);
    tbl[11] = mk(0, 0, 12'h030, 32'h0000_0005, 8'd0,   1, 0, 32'h0000_0005, 1, 1);
    tbl[12] = mk(0, 1, 12'h0AB, 32'h0,         8'd0,   1, 0, 32'h0000_00AB, 1, 1);
    tbl[13] = mk(0, 0, 12'h070, 32'h0000_000F, 8'd4,   0, 0, 32'hF000_0000, 1, 2);

    // Clock/reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset val2", val2, 32'd0);
    chk("reset carry", {31'b0, carry_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 14; t++) begin
      run_op(tbl[t].m, tbl[t].i, tbl[t].op, tbl[t].rm, tbl[t].rs, tbl[t].cin,
             tbl[t].restart, tbl[t].ev, tbl[t].ec, tbl[t].lat, $sformatf("vec%0d", t));
    end

    // Flush mid-shift: no done, result registers keep the previous value.
    run_op(1, 0, 12'h5A5, 32'h0, 8'd0, 0, 0, 32'h0000_05A5, 0, 1, "pre_flush");
    mem_rw = 0; imm = 0; shift_operand = 12'h010; val_rm = 32'hFFFF_FFFF; val_rs = 8'd40;
    carry_in = 1; start = 1;
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    chk("flush c1 busy", {31'b0, busy}, 32'd1);
    chk("flush c1 done", {31'b0, done}, 32'd0);
    @(posedge clk); #1; flush = 1;
    @(negedge clk);
    chk("flush c2 done", {31'b0, done}, 32'd0);
    @(posedge clk); #1; flush = 0;
    @(negedge clk);
    chk("flush c3 busy", {31'b0, busy}, 32'd0);
    chk("flush c3 done", {31'b0, done}, 32'd0);
    chk("flush c3 val2", val2, 32'h0000_05A5);
    chk("flush c3 carry", {31'b0, carry_out}, 32'd0);
    run_op(1, 0, 12'h123, 32'h0, 8'd0, 1, 0, 32'h0000_0123, 1, 1, "post_flush");

    // flush beats start in IDLE.
    mem_rw = 1; shift_operand = 12'h777; start = 1; flush = 1;
    @(posedge clk); #1; start = 0; flush = 0;
    @(negedge clk);
    chk("flush_start busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_start done", {31'b0, done}, 32'd0);
    chk("flush_start val2", val2, 32'h0000_0123);
    @(posedge clk); #1;

    // Asynchronous reset in C4 of a long shift.
    mem_rw = 0; imm = 0; shift_operand = 12'h010; val_rm = 32'hFFFF_FFFF; val_rs = 8'd40;
    start = 1;
    @(posedge clk); #1; start = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst busy", {31'b0, busy}, 32'd1);
    rst_n = 0;
    #1;
    chk("async_rst busy", {31'b0, busy}, 32'd0);
    chk("async_rst done", {31'b0, done}, 32'd0);
    chk("async_rst val2", val2, 32'd0);
    chk("async_rst carry", {31'b0, carry_out}, 32'd0);
    #2 rst_n = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // Randomized operations against the reference model.
    for (int n = 0; n < 60; n++) begin
      rm_m = ($urandom_range(0, 7) == 0);
      rm_i = ($urandom_range(0, 3) == 0);
      rm_cin = 1'($urandom_range(0, 1));
      r_op = 12'($urandom);
      if ($urandom_range(0, 3) == 0) r_op[11:7] = 5'd0;
      r_rm = $urandom;
      case ($urandom_range(0, 4))
        0: r_rs = 8'd0;
        1: r_rs = 8'd32;
        2: r_rs = 8'd33;
        3: r_rs = 8'($urandom_range(1, 40));
        default: r_rs = 8'($urandom_range(0, 255));
      endcase
      model(rm_m, rm_i, r_op, r_rm, r_rs, rm_cin, mv, mc, meff);
      exp_q.push_back(mv);
      run_op(rm_m, rm_i, r_op, r_rm, r_rs, rm_cin, 0, exp_q.pop_front(), mc,
             (meff + STEP - 1) / STEP + 1, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
